// File: rtl/decoder_scan_ctrl_if.sv
// Host-side bundle for decoder_scan_ctrl: scan control inputs and select/status outputs.
// The w/x/y/z one-hot lines exist only when DECODER_SCAN_ONEHOT_EN is defined.
interface decoder_scan_ctrl_if;
    logic       start;
    logic       stop;
    logic [1:0] mode;
    logic [3:0] sweeps;
    logic       a;
    logic       b;
    logic       busy;
    logic       step;
    logic       done;
`ifdef DECODER_SCAN_ONEHOT_EN
    logic       w;
    logic       x;
    logic       y;
    logic       z;

    modport master (output start, stop, mode, sweeps,
                    input  a, b, busy, step, done, w, x, y, z);
    modport slave  (input  start, stop, mode, sweeps,
                    output a, b, busy, step, done, w, x, y, z);
`else
    modport master (output start, stop, mode, sweeps,
                    input  a, b, busy, step, done);
    modport slave  (input  start, stop, mode, sweeps,
                    output a, b, busy, step, done);
`endif
endinterface

// File: rtl/decoder_scan_ctrl.sv
// Timed select-pattern generator (up / down / ping-pong) driving decoder_2x4 via a/b.
// Optional registered one-hot outputs w/x/y/z when DECODER_SCAN_ONEHOT_EN is defined.
//
// state  | meaning
// S_IDLE | waiting for start; sel holds last value
// S_RUN  | scanning; prescaler times the dwell of each sel value
// S_FINISH | programmed sweep count reached; done pulses for this one cycle
module decoder_scan_ctrl #(
    parameter int DIV   = 4,
    parameter int DIV_W = 8
) (
    input  logic clk,
    input  logic rst,
    decoder_scan_ctrl_if.slave bus
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

    localparam logic [1:0]       M_UP     = 2'b00;
    localparam logic [1:0]       M_DOWN   = 2'b01;
    localparam logic [1:0]       M_PP     = 2'b10;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    state_t           state_q, state_n;
    logic [DIV_W-1:0] presc_q, presc_n;
    logic [1:0]       sel_q, sel_n;
    logic [3:0]       cnt_q, cnt_n;
    logic [1:0]       mode_q, mode_n;
    logic [3:0]       sweeps_q, sweeps_n;
    logic             dir_down_q, dir_down_n;
    logic             seen3_q, seen3_n;
    logic             busy_q, busy_n;
    logic             step_q, step_n;
    logic             done_q, done_n;

    logic [1:0]       sel_adv;
    logic             dir_adv;
    logic             sweep_end;
    logic [3:0]       cnt_inc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            presc_q    <= '0;
            sel_q      <= 2'd0;
            cnt_q      <= 4'd0;
            mode_q     <= M_UP;
            sweeps_q   <= 4'd0;
            dir_down_q <= 1'b0;
            seen3_q    <= 1'b0;
            busy_q     <= 1'b0;
            step_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_n;
            presc_q    <= presc_n;
            sel_q      <= sel_n;
            cnt_q      <= cnt_n;
            mode_q     <= mode_n;
            sweeps_q   <= sweeps_n;
            dir_down_q <= dir_down_n;
            seen3_q    <= seen3_n;
            busy_q     <= busy_n;
            step_q     <= step_n;
            done_q     <= done_n;
        end
    end

    always_comb begin
        state_n    = state_q;
        presc_n    = presc_q;
        sel_n      = sel_q;
        cnt_n      = cnt_q;
        mode_n     = mode_q;
        sweeps_n   = sweeps_q;
        dir_down_n = dir_down_q;
        seen3_n    = seen3_q;
        step_n     = 1'b0;
        done_n     = 1'b0;
        sel_adv    = sel_q;
        dir_adv    = dir_down_q;
        sweep_end  = 1'b0;
        cnt_inc    = cnt_q + 4'd1;

        // Next select value and end-of-sweep detection for the latched mode.
        case (mode_q)
            M_DOWN: begin
                sel_adv   = sel_q - 2'd1;
                sweep_end = (sel_q == 2'd0);
            end
            M_PP: begin
                sweep_end = (sel_q == 2'd0) && seen3_q;
                if (sel_q == 2'd3) begin
                    sel_adv = 2'd2;
                    dir_adv = 1'b1;
                end else if (sel_q == 2'd0) begin
                    sel_adv = 2'd1;
                    dir_adv = 1'b0;
                end else if (dir_down_q) begin
                    sel_adv = sel_q - 2'd1;
                end else begin
                    sel_adv = sel_q + 2'd1;
                end
            end
            default: begin
                sel_adv   = sel_q + 2'd1;
                sweep_end = (sel_q == 2'd3);
            end
        endcase

        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.stop) begin
                    state_n    = S_RUN;
                    presc_n    = '0;
                    cnt_n      = 4'd0;
                    mode_n     = (bus.mode == 2'b11) ? M_UP : bus.mode;
                    sweeps_n   = bus.sweeps;
                    sel_n      = (bus.mode == M_DOWN) ? 2'd3 : 2'd0;
                    dir_down_n = 1'b0;
                    seen3_n    = 1'b0;
                end
            end
            S_RUN: begin
                if (bus.stop) begin
                    state_n = S_IDLE;
                    presc_n = '0;
                end else if (presc_q == DIV_LAST) begin
                    presc_n = '0;
                    if (sweep_end) cnt_n = cnt_inc;
                    if (sweep_end && (sweeps_q != 4'd0) && (cnt_inc == sweeps_q)) begin
                        state_n = S_FINISH;
                        done_n  = 1'b1;
                    end else begin
                        sel_n      = sel_adv;
                        dir_down_n = dir_adv;
                        step_n     = 1'b1;
                        if (sweep_end)
                            seen3_n = 1'b0;
                        else if (sel_q == 2'd3)
                            seen3_n = 1'b1;
                    end
                end else begin
                    presc_n = presc_q + 1'b1;
                end
            end
            S_FINISH: state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase

        busy_n = (state_n == S_RUN);
    end

    assign bus.a    = sel_q[1];
    assign bus.b    = sel_q[0];
    assign bus.busy = busy_q;
    assign bus.step = step_q;
    assign bus.done = done_q;

`ifdef DECODER_SCAN_ONEHOT_EN
    // Decoded from sel_n so the one-hot lines change on the same edge as a/b.
    logic [3:0] onehot_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            onehot_q <= 4'b1000;
        else
            onehot_q <= {sel_n == 2'd0, sel_n == 2'd1, sel_n == 2'd2, sel_n == 2'd3};
    end

    assign bus.w = onehot_q[3];
    assign bus.x = onehot_q[2];
    assign bus.y = onehot_q[1];
    assign bus.z = onehot_q[0];
`endif

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Scoreboard bench for decoder_scan_ctrl: three instances (DIV=1,2,4) share stimulus;
// expected step/done events come from a sequence-level model of the scan patterns.
module tb_decoder_scan_ctrl;

    typedef struct packed {
        logic [31:0] cyc;
        logic        is_done;
        logic [1:0]  sel;
    } ev_t;

    logic       clk;
    logic       rst;
    logic       start_d;
    logic       stop_d;
    logic [1:0] mode_d;
    logic [3:0] sweeps_d;

    logic [2:0] a_v, b_v, busy_v, step_v, done_v;
`ifdef DECODER_SCAN_ONEHOT_EN
    logic [2:0] w_v, x_v, y_v, z_v;
`endif

    int   cyc;
    int   checks;
    int   failures;
    int   divs [3] = '{1, 2, 4};
    ev_t  exp_q [3][$];
    logic [1:0] final_sel [3];
    logic [1:0] last_sel [3];

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        localparam int DV = (g == 0) ? 1 : (g == 1) ? 2 : 4;
        decoder_scan_ctrl_if bus ();
        assign bus.start  = start_d;
        assign bus.stop   = stop_d;
        assign bus.mode   = mode_d;
        assign bus.sweeps = sweeps_d;
        assign a_v[g]     = bus.a;
        assign b_v[g]     = bus.b;
        assign busy_v[g]  = bus.busy;
        assign step_v[g]  = bus.step;
        assign done_v[g]  = bus.done;
`ifdef DECODER_SCAN_ONEHOT_EN
        assign w_v[g] = bus.w;
        assign x_v[g] = bus.x;
        assign y_v[g] = bus.y;
        assign z_v[g] = bus.z;
`endif
        decoder_scan_ctrl #(.DIV(DV), .DIV_W(8)) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int g, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s dut=%0d cyc=%0d got=%0d required=%0d", name, g, cyc, got, exp);
        end
    endtask

    // Pattern value i of a scan: up 0..3 repeating, down 3..0, ping-pong 0,1,2,3,2,1 repeating.
    function automatic logic [1:0] sel_at(input int md, input int i);
        int k;
        case (md)
            1: k = 3 - (i % 4);
            2: begin
                k = i % 6;
                if (k > 3) k = 6 - k;
            end
            default: k = i % 4;
        endcase
        return 2'(k);
    endfunction

    function automatic int seq_len(input int md, input int sw);
        if (sw == 0) return 100000;
        return (md == 2) ? 6 * sw + 1 : 4 * sw;
    endfunction

    // Start edge is l0+1; run cycle c is observed at cyc = l0+1+c. cs<0 means no stop.
    task automatic push_expect(input int md, input int sw, input int cs, input int l0);
        ev_t e;
        int  n;
        int  lim;
        for (int g = 0; g < 3; g++) begin
            n   = seq_len(md, sw);
            lim = n * divs[g] - 1;
            if (cs >= 0 && cs < lim) lim = cs;
            for (int c = divs[g]; c <= lim; c += divs[g]) begin
                e.cyc = 32'(l0 + 1 + c);
                e.is_done = 1'b0;
                e.sel = sel_at(md, c / divs[g]);
                exp_q[g].push_back(e);
            end
            if (sw != 0 && (cs < 0 || cs >= n * divs[g])) begin
                e.cyc = 32'(l0 + 1 + n * divs[g]);
                e.is_done = 1'b1;
                e.sel = sel_at(md, n - 1);
                exp_q[g].push_back(e);
            end
            if (cs >= 0 && cs < n * divs[g])
                final_sel[g] = sel_at(md, cs / divs[g]);
            else
                final_sel[g] = sel_at(md, n - 1);
        end
    endtask

    task automatic run_scan(input int md, input int sw, input int cs, input bit poke);
        int l0;
        int endc;
        int runlen;
        @(negedge clk);
        l0 = cyc;
        mode_d = 2'(md);
        sweeps_d = 4'(sw);
        start_d = 1'b1;
        push_expect(md, sw, cs, l0);
        runlen = (sw == 0) ? 0 : seq_len(md, sw) * 4;
        endc = l0 + 3 + ((cs > runlen) ? cs : runlen);
        @(negedge clk);
        start_d = 1'b0;
        mode_d = 2'($urandom);
        sweeps_d = 4'($urandom);
        for (int g = 0; g < 3; g++) begin
            chk("start_busy", g, busy_v[g], 1);
            chk("start_sel", g, {a_v[g], b_v[g]}, (md == 1) ? 3 : 0);
        end
        while (cyc < endc) begin
            stop_d  = (cs >= 0 && cyc == l0 + 1 + cs);
            start_d = (poke && cyc == l0 + 3);
            @(negedge clk);
        end
        stop_d = 1'b0;
        start_d = 1'b0;
        for (int g = 0; g < 3; g++) begin
            chk("end_busy", g, busy_v[g], 0);
            chk("end_sel", g, {a_v[g], b_v[g]}, final_sel[g]);
            chk("missing_events", g, exp_q[g].size(), 0);
            last_sel[g] = final_sel[g];
        end
    endtask

    task automatic check_reset_vals(input string name);
        for (int g = 0; g < 3; g++) begin
            chk(name, g, {a_v[g], b_v[g], busy_v[g], step_v[g], done_v[g]}, 0);
`ifdef DECODER_SCAN_ONEHOT_EN
            chk({name, "_onehot"}, g, {w_v[g], x_v[g], y_v[g], z_v[g]}, 4'b1000);
`endif
        end
    endtask

    task automatic monitor();
        ev_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                for (int g = 0; g < 3; g++) begin
`ifdef DECODER_SCAN_ONEHOT_EN
                    chk("onehot", g, {w_v[g], x_v[g], y_v[g], z_v[g]}, 4'b1000 >> {a_v[g], b_v[g]});
`endif
                    if (step_v[g] || done_v[g]) begin
                        if (exp_q[g].size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL unexpected_event dut=%0d cyc=%0d step=%0d done=%0d sel=%0d required=none",
                                     g, cyc, step_v[g], done_v[g], {a_v[g], b_v[g]});
                        end else begin
                            e = exp_q[g].pop_front();
                            chk("ev_cyc", g, cyc, int'(e.cyc));
                            chk("ev_kind", g, {step_v[g], done_v[g]}, e.is_done ? 1 : 2);
                            chk("ev_sel", g, {a_v[g], b_v[g]}, e.sel);
                        end
                    end
                end
            end
        end
    endtask

    task automatic stimulus();
        int l0;
        int md;
        int sw;
        int cs;
        #3;
        check_reset_vals("reset_init");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int g = 0; g < 3; g++) last_sel[g] = 2'd0;

        run_scan(0, 1, -1, 1'b0);
        run_scan(2, 2, -1, 1'b0);
        run_scan(1, 0, 5, 1'b1);
        run_scan(3, 1, 15, 1'b0);

        // start and stop together in IDLE: nothing launches
        @(negedge clk);
        start_d = 1'b1;
        stop_d = 1'b1;
        mode_d = 2'd0;
        sweeps_d = 4'd1;
        @(negedge clk);
        start_d = 1'b0;
        stop_d = 1'b0;
        repeat (3) @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            chk("startstop_busy", g, busy_v[g], 0);
            chk("startstop_sel", g, {a_v[g], b_v[g]}, last_sel[g]);
        end

        // asynchronous reset in the middle of a continuous ping-pong scan
        @(negedge clk);
        l0 = cyc;
        mode_d = 2'd2;
        sweeps_d = 4'd0;
        start_d = 1'b1;
        push_expect(2, 0, 4, l0);
        @(negedge clk);
        start_d = 1'b0;
        while (cyc < l0 + 5) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset_vals("reset_async");
        for (int g = 0; g < 3; g++) begin
            chk("reset_pending", g, exp_q[g].size(), 0);
            exp_q[g].delete();
            last_sel[g] = 2'd0;
        end
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            md = int'($urandom_range(0, 3));
            sw = int'($urandom_range(0, 3));
            if (sw == 0)
                cs = int'($urandom_range(0, 30));
            else if ($urandom_range(0, 2) == 0)
                cs = int'($urandom_range(0, seq_len(md, sw) * 4 + 1));
            else
                cs = -1;
            run_scan(md, sw, cs, (sw == 0 && cs > 2));
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        start_d = 1'b0;
        stop_d = 1'b0;
        mode_d = 2'd0;
        sweeps_d = 4'd0;
        fork
            monitor();
            stimulus();
            begin
                #1000000;
                checks++;
                failures++;
                $display("FAIL timeout cyc=%0d required=completion", cyc);
            end
        join_any
        disable fork;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
